// File: rtl/energy_detect_pkg.sv
// Shared types and constants for the energy_detect carrier-sense block.
// Optional feature macro: ENERGY_DETECT_TIMESTAMP_EN (see energy_detect.sv).
package energy_detect_pkg;

  // Carrier FSM: two counting states on each side of the carrier level.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RISING  = 2'd1,
    BUSY    = 2'd2,
    FALLING = 2'd3
  } state_e;

  // Encoding of m_event.
  localparam logic EVENT_RISE = 1'b1;
  localparam logic EVENT_FALL = 1'b0;

  // Larger of two run limits; sizes the shared run counter.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/energy_detect_run_length_counter.sv
// Run-length counter: clears on a broken run, increments on a qualifying
// sample, and flags (and self-clears on) the sample that reaches the limit.
module run_length_counter
  import energy_detect_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             incr,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             hit
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W:0]   count_inc;

  // Next count: terminal sample wraps back to zero so the count never reaches the limit.
  always_comb begin
    count_inc = {1'b0, count_q} + (CNT_W+1)'(1);
    hit       = incr && (count_inc == {1'b0, limit});
    count_d   = count_q;
    if (clear || hit) begin
      count_d = '0;
    end else if (incr) begin
      count_d = count_inc[CNT_W-1:0];
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/energy_detect.sv
// Carrier-sense detector on a windowed-energy stream with hysteresis on both
// the threshold and the run length. Emits one rise/fall event per transition.
// Optional feature macro: ENERGY_DETECT_TIMESTAMP_EN adds m_timestamp, the
// index of the sample that completed the run (counted since reset, wrapping).
module energy_detect
  import energy_detect_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ON_COUNT  = 4,
  parameter int OFF_COUNT = 8,
  parameter int TS_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [2*WIDTH-1:0]    s_data,
  input  logic [2*WIDTH-1:0]    thresh_high,
  input  logic [2*WIDTH-1:0]    thresh_low,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_event,
`ifdef ENERGY_DETECT_TIMESTAMP_EN
  output logic [TS_WIDTH-1:0]   m_timestamp,
`endif
  output logic                  carrier
);

  localparam int CNT_W = $clog2(max2(ON_COUNT, OFF_COUNT) + 1);
  localparam logic [CNT_W-1:0] ON_LIM  = CNT_W'(ON_COUNT);
  localparam logic [CNT_W-1:0] OFF_LIM = CNT_W'(OFF_COUNT);

  // Zero-length runs or a zero-width timestamp make no sense; stop elaboration.
  if (ON_COUNT < 1 || OFF_COUNT < 1 || TS_WIDTH < 1) begin : g_param_check
    $error("energy_detect: ON_COUNT, OFF_COUNT and TS_WIDTH must be >= 1");
  end

  state_e           state_q, state_d;
  logic             m_valid_q, m_valid_d;
  logic             m_event_q, m_event_d;
  logic             carrier_q, carrier_d;
  logic             accept;
  logic             above, below;
  logic             counting_rise;
  logic             qualify;
  logic             run_incr, run_clear, run_hit;
  logic [CNT_W-1:0] run_limit;
  logic [CNT_W-1:0] run_count;

  // A pending event blocks input so no sample completes a run unreported.
  assign s_ready = !reset && (!m_valid_q || m_ready);
  assign accept  = s_valid && s_ready;

  // Only the comparison relevant to the current side of the carrier is used,
  // so overlapping thresholds (low > high) stay well defined.
  always_comb begin
    above         = (s_data >= thresh_high);
    below         = (s_data <  thresh_low);
    counting_rise = (state_q == IDLE) || (state_q == RISING);
    qualify       = counting_rise ? above : below;
    run_incr      = accept && qualify;
    run_clear     = accept && !qualify;
    run_limit     = counting_rise ? ON_LIM : OFF_LIM;
  end

  run_length_counter #(
    .CNT_W (CNT_W)
  ) u_run (
    .clk   (clk),
    .reset (reset),
    .clear (run_clear),
    .incr  (run_incr),
    .limit (run_limit),
    .count (run_count),
    .hit   (run_hit)
  );

  // FSM next state and event/carrier register next values.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (state_q)
        IDLE:    if (above)  state_d = RISING;
        RISING:  if (!above) state_d = IDLE;
        BUSY:    if (below)  state_d = FALLING;
        FALLING: if (!below) state_d = BUSY;
        default: state_d = IDLE;
      endcase
    end
    if (run_hit) begin
      state_d = counting_rise ? BUSY : IDLE;
    end

    m_valid_d = run_hit || (m_valid_q && !m_ready);
    m_event_d = m_event_q;
    carrier_d = carrier_q;
    if (run_hit) begin
      m_event_d = counting_rise ? EVENT_RISE : EVENT_FALL;
      carrier_d = counting_rise;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      m_valid_q <= 1'b0;
      m_event_q <= EVENT_FALL;
      carrier_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_event_q <= m_event_d;
      carrier_q <= carrier_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_event = m_event_q;
  assign carrier = carrier_q;

`ifdef ENERGY_DETECT_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt_q, ts_cnt_d;
  logic [TS_WIDTH-1:0] m_ts_q, m_ts_d;

  // Sample index counter and captured index of the completing sample.
  always_comb begin
    ts_cnt_d = accept  ? ts_cnt_q + TS_WIDTH'(1) : ts_cnt_q;
    m_ts_d   = run_hit ? ts_cnt_q : m_ts_q;
  end

  // Timestamp counter is control (reset); captured value is data.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_cnt_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_d;
    end
    m_ts_q <= m_ts_d;
  end

  assign m_timestamp = m_ts_q;
`endif

endmodule

// File: tb/tb_energy_detect.sv
// Directed bench for energy_detect (WIDTH=16, ON_COUNT=4, OFF_COUNT=8, TS_WIDTH=4).
module tb_energy_detect;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic [31:0] thresh_high = 32'd1000;
  logic [31:0] thresh_low  = 32'd500;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_event;
`ifdef ENERGY_DETECT_TIMESTAMP_EN
  logic [3:0]  m_timestamp;
`endif
  logic        carrier;

  int n_checks = 0;
  int n_pass   = 0;
  int ev_total = 0;
  int base;

  energy_detect #(
    .WIDTH     (16),
    .ON_COUNT  (4),
    .OFF_COUNT (8),
    .TS_WIDTH  (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .thresh_high (thresh_high),
    .thresh_low  (thresh_low),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_event     (m_event),
`ifdef ENERGY_DETECT_TIMESTAMP_EN
    .m_timestamp (m_timestamp),
`endif
    .carrier     (carrier)
  );

  always #5 clk = ~clk;

  // Count completed output handshakes.
  always @(posedge clk) begin
    if (m_valid && m_ready) ev_total <= ev_total + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = d;
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
    thresh_high = 32'd1000; thresh_low = 32'd500;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; s_valid = 1'b1; s_data = 32'd5000; m_ready = 1'b1;
    tick(); tick(); tick();
    n_checks++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready: got %0b want 0", s_ready); else n_pass++;
    n_checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %0b want 0", m_valid); else n_pass++;
    n_checks++; if (m_event !== 1'b0) $display("FAIL reset_m_event: got %0b want 0", m_event); else n_pass++;
    n_checks++; if (carrier !== 1'b0) $display("FAIL reset_carrier: got %0b want 0", carrier); else n_pass++;
    reset = 1'b0; s_valid = 1'b0;
    tick();
    n_checks++; if (s_ready !== 1'b1) $display("FAIL post_reset_s_ready: got %0b want 1", s_ready); else n_pass++;
  endtask

  task automatic test_rise();
    send(32'd1200, 3);
    n_checks++; if (m_valid !== 1'b0) $display("FAIL rise_early_valid: got %0b want 0", m_valid); else n_pass++;
    n_checks++; if (carrier !== 1'b0) $display("FAIL rise_early_carrier: got %0b want 0", carrier); else n_pass++;
    base = ev_total;
    send(32'd1200, 1);
    n_checks++; if (m_valid !== 1'b1) $display("FAIL rise_valid: got %0b want 1", m_valid); else n_pass++;
    n_checks++; if (m_event !== 1'b1) $display("FAIL rise_event: got %0b want 1", m_event); else n_pass++;
    n_checks++; if (carrier !== 1'b1) $display("FAIL rise_carrier: got %0b want 1", carrier); else n_pass++;
`ifdef ENERGY_DETECT_TIMESTAMP_EN
    n_checks++; if (m_timestamp !== 4'd3) $display("FAIL rise_ts: got %0d want 3", m_timestamp); else n_pass++;
`endif
    tick();
    n_checks++; if (m_valid !== 1'b0) $display("FAIL rise_consumed: got %0b want 0", m_valid); else n_pass++;
    n_checks++; if (ev_total - base !== 1) $display("FAIL rise_event_count: got %0d want 1", ev_total - base); else n_pass++;
  endtask

  // Continues from the BUSY state left by test_rise.
  task automatic test_fall();
    base = ev_total;
    send(32'd400, 7);
    send(32'd600, 1);
    send(32'd400, 7);
    n_checks++; if (m_valid !== 1'b0) $display("FAIL fall_early_valid: got %0b want 0", m_valid); else n_pass++;
    n_checks++; if (carrier !== 1'b1) $display("FAIL fall_early_carrier: got %0b want 1", carrier); else n_pass++;
    send(32'd400, 1);
    n_checks++; if (m_valid !== 1'b1) $display("FAIL fall_valid: got %0b want 1", m_valid); else n_pass++;
    n_checks++; if (m_event !== 1'b0) $display("FAIL fall_event: got %0b want 0", m_event); else n_pass++;
    n_checks++; if (carrier !== 1'b0) $display("FAIL fall_carrier: got %0b want 0", carrier); else n_pass++;
`ifdef ENERGY_DETECT_TIMESTAMP_EN
    // Sample index 19 wraps to 3 in a 4-bit counter.
    n_checks++; if (m_timestamp !== 4'd3) $display("FAIL fall_ts: got %0d want 3", m_timestamp); else n_pass++;
`endif
    tick();
    n_checks++; if (ev_total - base !== 1) $display("FAIL fall_event_count: got %0d want 1", ev_total - base); else n_pass++;
  endtask

  task automatic test_broken_run();
    do_reset();
    base = ev_total;
    send(32'd1200, 3);
    send(32'd800, 1);
    send(32'd1200, 3);
    tick();
    n_checks++; if (ev_total - base !== 0) $display("FAIL broken_event_count: got %0d want 0", ev_total - base); else n_pass++;
    n_checks++; if (carrier !== 1'b0) $display("FAIL broken_carrier: got %0b want 0", carrier); else n_pass++;
  endtask

  task automatic test_threshold_edges();
    do_reset();
    send(32'd1000, 4);
    n_checks++; if (m_valid !== 1'b1 || m_event !== 1'b1) $display("FAIL edge_high_rise: got valid=%0b event=%0b want 1 1", m_valid, m_event); else n_pass++;
    tick();
    send(32'd500, 8);
    n_checks++; if (carrier !== 1'b1 || m_valid !== 1'b0) $display("FAIL edge_low_hold: got carrier=%0b valid=%0b want 1 0", carrier, m_valid); else n_pass++;
    send(32'd499, 8);
    n_checks++; if (m_valid !== 1'b1 || m_event !== 1'b0 || carrier !== 1'b0) $display("FAIL edge_low_fall: got valid=%0b event=%0b carrier=%0b want 1 0 0", m_valid, m_event, carrier); else n_pass++;
  endtask

  task automatic test_inverted_thresholds();
    do_reset();
    thresh_low = 32'd2000;
    send(32'd1500, 4);
    n_checks++; if (m_valid !== 1'b1 || m_event !== 1'b1) $display("FAIL inv_rise: got valid=%0b event=%0b want 1 1", m_valid, m_event); else n_pass++;
    tick();
    send(32'd1500, 8);
    n_checks++; if (m_valid !== 1'b1 || m_event !== 1'b0 || carrier !== 1'b0) $display("FAIL inv_fall: got valid=%0b event=%0b carrier=%0b want 1 0 0", m_valid, m_event, carrier); else n_pass++;
    thresh_low = 32'd500;
  endtask

  task automatic test_backpressure();
    int bad;
    do_reset();
    m_ready = 1'b0;
    send(32'd1200, 4);
    n_checks++; if (m_valid !== 1'b1) $display("FAIL bp_valid: got %0b want 1", m_valid); else n_pass++;
    s_valid = 1'b1; s_data = 32'd400;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_event !== 1'b1)
        $display("FAIL bp_hold cycle %0d: got ready=%0b valid=%0b event=%0b want 0 1 1", i, s_ready, m_valid, m_event);
      else n_pass++;
`ifdef ENERGY_DETECT_TIMESTAMP_EN
      n_checks++; if (m_timestamp !== 4'd3) $display("FAIL bp_hold_ts cycle %0d: got %0d want 3", i, m_timestamp); else n_pass++;
`endif
    end
    m_ready = 1'b1;
    #1;
    n_checks++; if (s_ready !== 1'b1) $display("FAIL bp_release_ready: got %0b want 1", s_ready); else n_pass++;
    for (int i = 0; i < 8; i++) tick();
    s_valid = 1'b0;
    n_checks++; if (m_valid !== 1'b1 || m_event !== 1'b0 || carrier !== 1'b0) $display("FAIL bp_fall: got valid=%0b event=%0b carrier=%0b want 1 0 0", m_valid, m_event, carrier); else n_pass++;
`ifdef ENERGY_DETECT_TIMESTAMP_EN
    n_checks++; if (m_timestamp !== 4'd11) $display("FAIL bp_fall_ts: got %0d want 11", m_timestamp); else n_pass++;
`endif
    tick();
  endtask

  task automatic test_reset_midrun();
    do_reset();
    send(32'd1200, 2);
    do_reset();
    send(32'd1200, 3);
    n_checks++; if (m_valid !== 1'b0) $display("FAIL midrun_no_event: got %0b want 0", m_valid); else n_pass++;
    send(32'd1200, 1);
    n_checks++; if (m_valid !== 1'b1) $display("FAIL midrun_rise: got %0b want 1", m_valid); else n_pass++;
`ifdef ENERGY_DETECT_TIMESTAMP_EN
    n_checks++; if (m_timestamp !== 4'd3) $display("FAIL midrun_ts: got %0d want 3", m_timestamp); else n_pass++;
`endif
    m_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_checks++; if (m_valid !== 1'b0 || carrier !== 1'b0) $display("FAIL pending_discard: got valid=%0b carrier=%0b want 0 0", m_valid, carrier); else n_pass++;
    n_checks++; if (s_ready !== 1'b1) $display("FAIL pending_discard_ready: got %0b want 1", s_ready); else n_pass++;
    m_ready = 1'b1;
  endtask

  task automatic test_wrap();
    do_reset();
    send(32'd100, 18);
    send(32'd1200, 4);
    n_checks++; if (m_valid !== 1'b1 || m_event !== 1'b1) $display("FAIL wrap_rise: got valid=%0b event=%0b want 1 1", m_valid, m_event); else n_pass++;
`ifdef ENERGY_DETECT_TIMESTAMP_EN
    n_checks++; if (m_timestamp !== 4'd5) $display("FAIL wrap_ts: got %0d want 5", m_timestamp); else n_pass++;
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_rise();
    test_fall();
    test_broken_run();
    test_threshold_edges();
    test_inverted_thresholds();
    test_backpressure();
    test_reset_midrun();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
